// File: rtl/click_pkg.sv
// Shared definitions for the click pulse-train transmitter.
package click_pkg;

  localparam int CW_DEFAULT = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] RAND_MASK = 16'h000F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } click_state_t;

endpackage

// File: rtl/click_lfsr16.sv
// Step-enabled 16-bit maximal-length Fibonacci LFSR with synchronous reset.
module click_lfsr16
  import click_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else if (step) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/click_pulser.sv
// Pulse-train transmitter: programmable width, gap and count on one registered line.
// Optional random gap extension is enabled with CLICK_PULSER_RANDGAP_EN.
module click_pulser
  import click_pkg::*;
#(
  parameter int CW      = CW_DEFAULT,
  parameter int MIN_GAP = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] width,
  input  logic [CW-1:0] gap,
  input  logic [CW-1:0] count,
`ifdef CLICK_PULSER_RANDGAP_EN
  input  logic          randgap,
`endif
  output logic          click,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] sent
);

  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] MIN_GAP_CW = CW'(MIN_GAP);

  click_state_t  state;
  logic [CW-1:0] w_lat;
  logic [CW-1:0] g_lat;
  logic [CW-1:0] c_lat;
  logic [CW-1:0] timer;

  logic [CW-1:0] eff_width;
  logic [CW-1:0] eff_gap;
  logic [CW-1:0] sent_next;
  logic [CW-1:0] low_len;
  logic          last_high;
  logic          finish;
  logic          enter_low;

  assign eff_width = (width == '0) ? ONE : width;
  assign eff_gap   = (gap < MIN_GAP_CW) ? MIN_GAP_CW : gap;
  assign sent_next = sent + ONE;
  assign last_high = (state == HIGH) && (timer == '0);
  assign finish    = (c_lat != '0) && (sent_next == c_lat);
  assign enter_low = last_high && !stop && !finish;

`ifdef CLICK_PULSER_RANDGAP_EN
  logic        rg_lat;
  logic [15:0] lfsr_q;

  click_lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .step  (enter_low),
    .q     (lfsr_q)
  );

  // The interval uses the current LFSR value; the LFSR steps as LOW is entered.
  assign low_len = rg_lat ? (g_lat + CW'(lfsr_q & RAND_MASK)) : g_lat;
`else
  assign low_len = g_lat;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      click <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sent  <= '0;
      w_lat <= '0;
      g_lat <= '0;
      c_lat <= '0;
      timer <= '0;
`ifdef CLICK_PULSER_RANDGAP_EN
      rg_lat <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= HIGH;
            click <= 1'b1;
            busy  <= 1'b1;
            sent  <= '0;
            w_lat <= eff_width;
            g_lat <= eff_gap;
            c_lat <= count;
            timer <= eff_width - ONE;
`ifdef CLICK_PULSER_RANDGAP_EN
            rg_lat <= randgap;
`endif
          end
        end
        HIGH: begin
          if (stop) begin
            // A truncated high phase is never counted.
            state <= IDLE;
            click <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (last_high) begin
            sent <= sent_next;
            if (finish) begin
              state <= IDLE;
              click <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (enter_low) begin
              state <= LOW;
              click <= 1'b0;
              timer <= low_len - ONE;
            end
          end else begin
            timer <= timer - ONE;
          end
        end
        LOW: begin
          if (stop) begin
            state <= IDLE;
            click <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (timer == '0) begin
            state <= HIGH;
            click <= 1'b1;
            timer <= w_lat - ONE;
          end else begin
            timer <= timer - ONE;
          end
        end
        default: begin
          state <= IDLE;
          click <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/click_pulser.md
Name: click_pulser

Overview:
- Pulse-train transmitter. It is the drive side of the pulse edge detection front end.
- Generates click pulses with programmable high width, low gap and count on a single output line.
- Used as an on-chip stimulus source for the registration channels and for loopback self-test.
- Every pulse it emits must register as exactly one edge at an edge-detecting receiver on the same clock.

Parameters:
- CW, 16: width of the width, gap and count fields and of the internal counters.
- MIN_GAP, 1: minimum low time in clocks between pulses. It guarantees the receiver re-arms. Must be ≥1.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle strobe; begins a train when idle.
- stop  in  1  one-cycle strobe; aborts a running train.
- width  in  CW  high time per pulse in clocks; latched on accepted start.
- gap  in  CW  low time between pulses in clocks; latched on accepted start.
- count  in  CW  number of pulses; 0 = continuous until stop. Latched on accepted start.
- click  out  1  generated pulse line; registered output.
- busy  out  1  high while a train is in progress.
- done  out  1  one-cycle strobe when a train ends, by completion or by stop.
- sent  out  CW  pulses emitted in the current or last train; wraps modulo 2^CW.

Behaviour:
- Reset values, effective at the first posedge with reset=1:
  - click=0, busy=0, done=0, sent=0, state=IDLE, all counters 0.
  - Reset mid-train drops click on that edge; no done strobe is issued.
- All outputs are registered. There is no combinational path from any input to any output.
- Field rules on latch:
  - eff_width = max(width,1).
  - eff_gap = max(gap,MIN_GAP).
  - count is used as given.
- State IDLE:
  - click=0, busy=0.
  - start=1 → latch fields, sent←0, go to HIGH.
  - click rises on the edge that samples start (1-cycle latency); busy rises on the same edge.
- State HIGH:
  - click=1 for exactly eff_width cycles.
  - On the last high cycle, sent←sent+1.
  - If count≠0 and the new sent value equals count → IDLE, click←0, busy←0, done←1 for one cycle.
  - Otherwise → LOW.
- State LOW:
  - click=0 for exactly eff_gap cycles, then → HIGH.
- Pulse period = eff_width+eff_gap cycles.
- start while busy is ignored. Fields are not re-latched.
- stop while busy, any state:
  - Next edge: click←0, busy←0, done←1, → IDLE.
  - sent keeps the completed-pulse count. A truncated high phase is not counted.
- stop while idle is ignored.
- start and stop both high while idle: start wins. stop is ignored because the block is not yet busy.
- Continuous mode (count=0): sent wraps 2^CW−1→0 with no effect on the train.
- done is high for exactly one cycle per train end, on the same edge busy falls.

Optional Feature:
- Macro: CLICK_PULSER_RANDGAP_EN.
- When defined:
  - A 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances once per entry to LOW.
  - Gap for that interval = eff_gap + (lfsr & 16'h000F), i.e. eff_gap to eff_gap+15 cycles.
  - An added input randgap (1 bit) enables the random offset per train; it is latched on start.
- When undefined: no LFSR, no randgap port, gap is always eff_gap.

Decomposition:
- Shared package click_pkg holds:
  - state encoding (IDLE=2'd0, HIGH=2'd1, LOW=2'd2);
  - CW default;
  - LFSR seed and taps constants.
- One natural sub-module: click_lfsr16, the step-enabled LFSR with synchronous reset. It is instantiated only under CLICK_PULSER_RANDGAP_EN.

Test Plan:
- width=3, gap=2, count=4, start at cycle 10 → click high 11–13, 16–18, 21–23, 26–28; done at 29; sent=4; busy 11–28.
- width=0, gap=0, count=2 → treated as 1/1: click 1,0,1 pattern; a clicklatch receiver on the same clock registers exactly 2 pulses.
- count=0, width=1, gap=1, stop after 7 pulses mid-LOW → click stays 0, done one cycle, sent=7, busy falls with done.
- Running train, second start with width=9 mid-train → ignored: timing unchanged, fields not re-latched. Then reset asserted during HIGH → click=0 and sent=0 at that edge, no done.
- CW=4, count=0, 20 pulses → sent wraps 15→0 and reads 4 at end; train uninterrupted.
- With CLICK_PULSER_RANDGAP_EN, randgap=1, gap=2 → every low interval is in 2..17 and matches the LFSR reference model sequence from seed 16'hACE1.
